// File: rtl/icache_loader_pkg.sv
// Shared types and constants for the instruction-cache program loader.
package icache_loader_pkg;

    localparam logic [7:0] LOADER_SYNC = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA_HI,
        DATA_LO,
        CHECK
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_WAIT_START,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    typedef struct packed {
        logic        valid;
        logic [15:0] addr;
        logic [15:0] data;
    } icache_write_port;

endpackage

// File: rtl/icache_loader_uart_rx.sv
// 8N1 UART byte receiver: synchroniser, mid-bit sampling down-counter, shift register.
//
// state         | meaning
// RX_WAIT_START | line idle, waiting for a falling edge
// RX_START      | re-checking the start bit at half a bit-time
// RX_DATA       | sampling 8 data bits, LSB first, at mid-bit
// RX_STOP       | sampling the stop bit; emits the byte or a framing error
module uart_rx_byte
    import icache_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_rxd,
    output logic       o_byte_valid,
    output logic [7:0] o_byte_data,
    output logic       o_frame_err
);

    localparam int             CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]  CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]  CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]    r_sync;
    logic          r_rxd_prev;
    rx_state_t     r_state;
    rx_state_t     w_next;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_byte_valid;
    logic          r_frame_err;

    logic w_rxd;
    logic w_fall;
    logic w_tick;

    assign w_rxd  = r_sync[1];
    assign w_fall = r_rxd_prev & ~w_rxd;
    assign w_tick = (r_cnt == '0);

    // Synchroniser and edge history; reset low so a line that is already low
    // after reset is never mistaken for a fresh start edge.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sync     <= 2'b00;
            r_rxd_prev <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], i_rxd};
            r_rxd_prev <= w_rxd;
        end
    end

    // Receiver state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= RX_WAIT_START;
        else         r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            RX_WAIT_START: if (w_fall) w_next = RX_START;
            RX_START:      if (w_tick) w_next = w_rxd ? RX_WAIT_START : RX_DATA;
            RX_DATA:       if (w_tick && r_bit == 3'd7) w_next = RX_STOP;
            RX_STOP:       if (w_tick) w_next = RX_WAIT_START;
            default:       w_next = RX_WAIT_START;
        endcase
    end

    // Bit timer, shift register and one-cycle result strobes.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt        <= '0;
            r_bit        <= 3'd0;
            r_shift      <= 8'h00;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_state)
                RX_WAIT_START: begin
                    r_cnt <= CNT_HALF;
                    r_bit <= 3'd0;
                end
                RX_START: r_cnt <= w_tick ? CNT_FULL : r_cnt - CW'(1);
                RX_DATA: begin
                    if (w_tick) begin
                        r_shift <= {w_rxd, r_shift[7:1]};
                        r_bit   <= r_bit + 3'd1;
                        r_cnt   <= CNT_FULL;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                RX_STOP: begin
                    if (w_tick) begin
                        r_byte_valid <= w_rxd;
                        r_frame_err  <= ~w_rxd;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign o_byte_valid = r_byte_valid;
    assign o_byte_data  = r_shift;
    assign o_frame_err  = r_frame_err;

endmodule

// File: rtl/icache_loader.sv
// Program-load engine: parses a framed image from UART and writes it into the icache.
//
// state   | meaning
// IDLE    | hunting for the 0xA5 sync byte
// LEN_HI  | expecting word-count high byte
// LEN_LO  | expecting word-count low byte; range check
// DATA_HI | expecting instruction high byte
// DATA_LO | expecting instruction low byte; issues the write
// CHECK   | expecting XOR checksum byte
module icache_loader
    import icache_loader_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int IMEM_WORDS = 1024
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_uart_rxd,
    output logic        o_icache_we,
    output logic [15:0] o_icache_addr,
    output logic [15:0] o_icache_wdata,
    output logic        o_core_hold,
    output logic        o_load_done,
    output logic        o_load_error,
    output logic [15:0] o_words_loaded
);

    localparam int          CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam logic [15:0] MAX_WORDS    = 16'(IMEM_WORDS);

    logic             w_byte_valid;
    logic [7:0]       w_byte;
    logic             w_frame_err;

    loader_state_t    r_state;
    loader_state_t    w_next;
    logic [7:0]       r_hi;
    logic [15:0]      r_len;
    logic [15:0]      r_addr;
    logic [7:0]       r_xor;
    icache_write_port r_wport;
    logic             r_hold;
    logic             r_done;
    logic             r_err;
    logic [15:0]      r_words;

    logic [15:0]      w_len;
    logic [15:0]      w_addr_inc;
    logic             w_abort;

    assign w_len      = {r_hi, w_byte};
    assign w_addr_inc = r_addr + 16'd1;
    assign w_abort    = w_frame_err && (r_state != IDLE);

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_rxd       (i_uart_rxd),
        .o_byte_valid(w_byte_valid),
        .o_byte_data (w_byte),
        .o_frame_err (w_frame_err)
    );

    // Parser state register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Parser next-state decode; a framing error abandons any frame in progress.
    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = IDLE;
        end else if (w_byte_valid) begin
            case (r_state)
                IDLE:    if (w_byte == LOADER_SYNC) w_next = LEN_HI;
                LEN_HI:  w_next = LEN_LO;
                LEN_LO: begin
                    if (w_len > MAX_WORDS)  w_next = IDLE;
                    else if (w_len == '0)   w_next = CHECK;
                    else                    w_next = DATA_HI;
                end
                DATA_HI: w_next = DATA_LO;
                DATA_LO: w_next = (w_addr_inc == r_len) ? CHECK : DATA_HI;
                CHECK:   w_next = IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    // Frame datapath: length, address, running XOR, write port and status flags.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_hi    <= 8'h00;
            r_len   <= 16'd0;
            r_addr  <= 16'd0;
            r_xor   <= 8'h00;
            r_wport <= '0;
            r_hold  <= 1'b1;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_words <= 16'd0;
        end else begin
            r_wport.valid <= 1'b0;
            if (w_abort) begin
                r_err <= 1'b1;
            end else if (w_byte_valid) begin
                case (r_state)
                    IDLE: begin
                        if (w_byte == LOADER_SYNC) begin
                            r_hold  <= 1'b1;
                            r_done  <= 1'b0;
                            r_err   <= 1'b0;
                            r_words <= 16'd0;
                            r_addr  <= 16'd0;
                            r_xor   <= 8'h00;
                        end
                    end
                    LEN_HI: begin
                        r_hi  <= w_byte;
                        r_xor <= r_xor ^ w_byte;
                    end
                    LEN_LO: begin
                        r_len <= w_len;
                        r_xor <= r_xor ^ w_byte;
                        if (w_len > MAX_WORDS) r_err <= 1'b1;
                    end
                    DATA_HI: begin
                        r_hi  <= w_byte;
                        r_xor <= r_xor ^ w_byte;
                    end
                    DATA_LO: begin
                        r_wport <= '{valid: 1'b1, addr: r_addr, data: {r_hi, w_byte}};
                        r_addr  <= w_addr_inc;
                        r_words <= w_addr_inc;
                        r_xor   <= r_xor ^ w_byte;
                    end
                    CHECK: begin
                        if (w_byte == r_xor) begin
                            r_done <= 1'b1;
                            r_hold <= 1'b0;
                            r_err  <= 1'b0;
                        end else begin
                            r_err  <= 1'b1;
                        end
                    end
                    default: r_err <= r_err;
                endcase
            end
        end
    end

    assign o_icache_we    = r_wport.valid;
    assign o_icache_addr  = r_wport.addr;
    assign o_icache_wdata = r_wport.data;
    assign o_core_hold    = r_hold;
    assign o_load_done    = r_done;
    assign o_load_error   = r_err;
    assign o_words_loaded = r_words;

endmodule

// File: tb/tb_icache_loader.sv
// Directed bench for icache_loader: 10 clocks per bit, 16-word icache.
`timescale 1ns/1ps
module tb_icache_loader;

    localparam int CPB = 10;

    logic        clk;
    logic        rst;
    logic        rxd;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        hold;
    logic        done;
    logic        err;
    logic [15:0] words;

    int n_checks = 0;
    int n_errors = 0;

    // Write log filled by the monitor; tasks only read it.
    logic [15:0] wr_a[$];
    logic [15:0] wr_d[$];
    logic [15:0] wr_w[$];
    int          b2b_cnt = 0;
    logic        we_prev = 1'b0;

    icache_loader #(
        .CLK_HZ    (1000000),
        .BAUD      (100000),
        .IMEM_WORDS(16)
    ) dut (
        .i_clk         (clk),
        .i_reset       (rst),
        .i_uart_rxd    (rxd),
        .o_icache_we   (we),
        .o_icache_addr (addr),
        .o_icache_wdata(wdata),
        .o_core_hold   (hold),
        .o_load_done   (done),
        .o_load_error  (err),
        .o_words_loaded(words)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we) begin
            wr_a.push_back(addr);
            wr_d.push_back(wdata);
            wr_w.push_back(words);
        end
        if (we && we_prev) b2b_cnt = b2b_cnt + 1;
        we_prev = we;
    end

    task automatic bit_time(input logic v);
        rxd = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(b[i]);
        bit_time(stop);
        bit_time(1'b1);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rxd = 1'b1;
        #3;
        n_checks++; if (we !== 1'b0)      begin n_errors++; $display("FAIL reset_we got=%b exp=0", we); end
        n_checks++; if (addr !== 16'h0)   begin n_errors++; $display("FAIL reset_addr got=%h exp=0", addr); end
        n_checks++; if (wdata !== 16'h0)  begin n_errors++; $display("FAIL reset_wdata got=%h exp=0", wdata); end
        n_checks++; if (hold !== 1'b1)    begin n_errors++; $display("FAIL reset_hold got=%b exp=1", hold); end
        n_checks++; if (done !== 1'b0)    begin n_errors++; $display("FAIL reset_done got=%b exp=0", done); end
        n_checks++; if (err !== 1'b0)     begin n_errors++; $display("FAIL reset_err got=%b exp=0", err); end
        n_checks++; if (words !== 16'h0)  begin n_errors++; $display("FAIL reset_words got=%h exp=0", words); end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        repeat (2 * CPB) @(posedge clk);
        #1;
    endtask

    task automatic test_valid_frame;
        int base = wr_a.size();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
        send_byte(8'h42);
        n_checks++; if (wr_a.size() - base !== 2) begin n_errors++; $display("FAIL valid_nwrites got=%0d exp=2", wr_a.size() - base); end
        if (wr_a.size() - base >= 2) begin
            n_checks++; if (wr_a[base] !== 16'd0)      begin n_errors++; $display("FAIL valid_addr0 got=%h exp=0", wr_a[base]); end
            n_checks++; if (wr_d[base] !== 16'h1234)   begin n_errors++; $display("FAIL valid_data0 got=%h exp=1234", wr_d[base]); end
            n_checks++; if (wr_w[base] !== 16'd1)      begin n_errors++; $display("FAIL valid_words_at0 got=%h exp=1", wr_w[base]); end
            n_checks++; if (wr_a[base+1] !== 16'd1)    begin n_errors++; $display("FAIL valid_addr1 got=%h exp=1", wr_a[base+1]); end
            n_checks++; if (wr_d[base+1] !== 16'hABCD) begin n_errors++; $display("FAIL valid_data1 got=%h exp=abcd", wr_d[base+1]); end
        end
        n_checks++; if (words !== 16'd2) begin n_errors++; $display("FAIL valid_words got=%0d exp=2", words); end
        n_checks++; if (done !== 1'b1)   begin n_errors++; $display("FAIL valid_done got=%b exp=1", done); end
        n_checks++; if (hold !== 1'b0)   begin n_errors++; $display("FAIL valid_hold got=%b exp=0", hold); end
        n_checks++; if (err !== 1'b0)    begin n_errors++; $display("FAIL valid_err got=%b exp=0", err); end
        n_checks++; if (b2b_cnt !== 0)   begin n_errors++; $display("FAIL valid_b2b got=%0d exp=0", b2b_cnt); end
    endtask

    task automatic test_bad_checksum;
        int base = wr_a.size();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h12); send_byte(8'h34); send_byte(8'hAB); send_byte(8'hCD);
        send_byte(8'h43);
        n_checks++; if (wr_a.size() - base !== 2) begin n_errors++; $display("FAIL badchk_nwrites got=%0d exp=2", wr_a.size() - base); end
        n_checks++; if (err !== 1'b1)  begin n_errors++; $display("FAIL badchk_err got=%b exp=1", err); end
        n_checks++; if (hold !== 1'b1) begin n_errors++; $display("FAIL badchk_hold got=%b exp=1", hold); end
        n_checks++; if (done !== 1'b0) begin n_errors++; $display("FAIL badchk_done got=%b exp=0", done); end
    endtask

    task automatic test_overflow;
        int base = wr_a.size();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h11);
        n_checks++; if (err !== 1'b1)  begin n_errors++; $display("FAIL ovf_err got=%b exp=1", err); end
        n_checks++; if (hold !== 1'b1) begin n_errors++; $display("FAIL ovf_hold got=%b exp=1", hold); end
        send_byte(8'h11);
        n_checks++; if (wr_a.size() - base !== 0) begin n_errors++; $display("FAIL ovf_nwrites got=%0d exp=0", wr_a.size() - base); end
        n_checks++; if (err !== 1'b1)  begin n_errors++; $display("FAIL ovf_err_after got=%b exp=1", err); end
    endtask

    task automatic test_zero_len;
        int base = wr_a.size();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        n_checks++; if (wr_a.size() - base !== 0) begin n_errors++; $display("FAIL zero_nwrites got=%0d exp=0", wr_a.size() - base); end
        n_checks++; if (done !== 1'b1)   begin n_errors++; $display("FAIL zero_done got=%b exp=1", done); end
        n_checks++; if (hold !== 1'b0)   begin n_errors++; $display("FAIL zero_hold got=%b exp=0", hold); end
        n_checks++; if (err !== 1'b0)    begin n_errors++; $display("FAIL zero_err got=%b exp=0", err); end
        n_checks++; if (words !== 16'd0) begin n_errors++; $display("FAIL zero_words got=%0d exp=0", words); end
    endtask

    task automatic send_beef_frame(input string tag);
        int base = wr_a.size();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
        send_byte(8'hBE); send_byte(8'hEF); send_byte(8'h50);
        n_checks++; if (wr_a.size() - base !== 1) begin n_errors++; $display("FAIL %s_nwrites got=%0d exp=1", tag, wr_a.size() - base); end
        if (wr_a.size() - base >= 1) begin
            n_checks++; if (wr_a[base] !== 16'd0)    begin n_errors++; $display("FAIL %s_addr got=%h exp=0", tag, wr_a[base]); end
            n_checks++; if (wr_d[base] !== 16'hBEEF) begin n_errors++; $display("FAIL %s_data got=%h exp=beef", tag, wr_d[base]); end
        end
        n_checks++; if (done !== 1'b1)   begin n_errors++; $display("FAIL %s_done got=%b exp=1", tag, done); end
        n_checks++; if (hold !== 1'b0)   begin n_errors++; $display("FAIL %s_hold got=%b exp=0", tag, hold); end
        n_checks++; if (err !== 1'b0)    begin n_errors++; $display("FAIL %s_err got=%b exp=0", tag, err); end
        n_checks++; if (words !== 16'd1) begin n_errors++; $display("FAIL %s_words got=%0d exp=1", tag, words); end
    endtask

    task automatic test_frame_error;
        int base = wr_a.size();
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h12, 1'b0);
        n_checks++; if (wr_a.size() - base !== 0) begin n_errors++; $display("FAIL ferr_nwrites got=%0d exp=0", wr_a.size() - base); end
        n_checks++; if (err !== 1'b1)  begin n_errors++; $display("FAIL ferr_err got=%b exp=1", err); end
        n_checks++; if (hold !== 1'b1) begin n_errors++; $display("FAIL ferr_hold got=%b exp=1", hold); end
        send_beef_frame("ferr_reload");
    endtask

    task automatic test_reset_mid_frame;
        send_byte(8'hA5); send_byte(8'h00); send_byte(8'h04);
        send_byte(8'h00); send_byte(8'h01);
        n_checks++; if (words !== 16'd1) begin n_errors++; $display("FAIL mid_words_before got=%0d exp=1", words); end
        // Start of word 1 high byte (0x02): start bit then four data bits.
        bit_time(1'b0);
        bit_time(1'b0); bit_time(1'b1); bit_time(1'b0); bit_time(1'b0);
        rst = 1'b1;
        #1;
        n_checks++; if (we !== 1'b0)     begin n_errors++; $display("FAIL mid_we got=%b exp=0", we); end
        n_checks++; if (addr !== 16'h0)  begin n_errors++; $display("FAIL mid_addr got=%h exp=0", addr); end
        n_checks++; if (wdata !== 16'h0) begin n_errors++; $display("FAIL mid_wdata got=%h exp=0", wdata); end
        n_checks++; if (hold !== 1'b1)   begin n_errors++; $display("FAIL mid_hold got=%b exp=1", hold); end
        n_checks++; if (done !== 1'b0)   begin n_errors++; $display("FAIL mid_done got=%b exp=0", done); end
        n_checks++; if (err !== 1'b0)    begin n_errors++; $display("FAIL mid_err got=%b exp=0", err); end
        n_checks++; if (words !== 16'h0) begin n_errors++; $display("FAIL mid_words got=%h exp=0", words); end
        @(posedge clk);
        #1 rst = 1'b0;
        rxd = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1;
        send_beef_frame("mid_reload");
    endtask

    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        test_reset();
        test_valid_frame();
        test_bad_checksum();
        test_overflow();
        test_zero_len();
        test_frame_error();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/icache_loader.md
# icache_loader

Program-load engine that writes the instruction cache: the writer side for the core's instruction fetch port (`raw_instruction` by `pc`). It deserialises a framed program image from the host over UART, writes each 16-bit instruction word into the icache RAM, and holds the core until a complete, checksum-valid image is resident. It sits beside `dma_uart` at top level. The host sends the program through this block, and `dma_uart` then handles data traffic.

## Interface
Parameters:
- `CLK_HZ`, 50000000, system clock frequency.
- `BAUD`, 115200, UART bit rate. `CLKS_PER_BIT = CLK_HZ/BAUD`, integer-truncated; must be ≥ 4.
- `IMEM_WORDS`, 1024, icache capacity in 16-bit words.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `uart_rxd`  in  1  UART receive pin, idle high, 8N1.
- `icache_we`  out  1  one-cycle write strobe.
- `icache_addr`  out  16  word address.
- `icache_wdata`  out  16  instruction word.
- `core_hold`  out  1  high while no valid program is loaded. Drives reset/freeze of the pipeline.
- `load_done`  out  1  sticky; a valid image is loaded.
- `load_error`  out  1  sticky; the last frame failed.
- `words_loaded`  out  16  words written by the current or last frame.

## Operation
- Reset values: `icache_we=0`, `icache_addr=0`, `icache_wdata=0`, `core_hold=1`, `load_done=0`, `load_error=0`, `words_loaded=0`. The FSM resets to IDLE and the UART receiver resets to WAIT_START.
- UART receiver:
  - `uart_rxd` passes through a 2-flop synchroniser.
  - A falling edge in WAIT_START starts a byte. The start bit is re-sampled at `CLKS_PER_BIT/2`; if it reads high, the event is treated as a glitch and the receiver returns to WAIT_START.
  - The 8 data bits are sampled LSB first, each at mid-bit. The stop bit is sampled at mid-bit.
  - If the stop bit reads 1, `byte_valid` pulses for one cycle with the byte.
  - If the stop bit reads 0, this is a framing error: no byte is emitted, and a `frame_err` pulse is sent to the parser.
- Frame format: `0xA5`, LEN_HI, LEN_LO, then N words sent high byte first, then CHK.
  - N = {LEN_HI, LEN_LO}.
  - CHK = XOR of every byte after `0xA5`, including both length bytes and all data bytes.
- Parser FSM, with transitions on `byte_valid`:
  - IDLE: `0xA5` moves to LEN_HI. All other bytes are ignored.
  - LEN_HI moves to LEN_LO.
  - LEN_LO:
    - If N > `IMEM_WORDS`: set `load_error`, return to IDLE.
    - If N = 0: go to CHECK.
    - Otherwise: go to DATA_HI.
  - DATA_HI moves to DATA_LO.
  - DATA_LO: write the word, increment the address. If the address is now N, go to CHECK; otherwise go to DATA_HI.
  - CHECK:
    - Match: `load_done=1`, `core_hold=0`, `load_error=0`.
    - Mismatch: `load_error=1`. `core_hold` stays 1.
    - Either way, return to IDLE.
- Accepting `0xA5` in IDLE starts a new frame. It sets `core_hold=1`, `load_done=0`, `load_error=0`, `words_loaded=0`, address to 0, and the running XOR to 0. This applies even after a successful load, so the host can reload.
- A `frame_err` in any non-IDLE state sets `load_error` and returns the FSM to IDLE. A `frame_err` in IDLE is ignored.
- Writes are not rolled back on error. `core_hold` gating makes partially written contents harmless.

## Timing
- `byte_valid` is asserted one cycle after the stop-bit sample.
- In DATA_LO, `icache_we` pulses the cycle after `byte_valid`. `icache_addr`, `icache_wdata` and `words_loaded` are registered with it and are valid in that same cycle.
- Writes are never back-to-back; consecutive writes are at least 20 bit-times apart.
- `core_hold` falls, and `load_done` rises, in the cycle after CHK's `byte_valid`.
- Asynchronous reset mid-frame:
  - All outputs return to their reset values immediately.
  - A partially received UART byte is discarded.
  - The receiver stays in WAIT_START until the next falling edge.

## Structure
- A shared package holds:
  - the `LOADER_SYNC = 8'hA5` constant;
  - the parser state enum (IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK);
  - the `icache_write_port` struct {valid, addr[15:0], data[15:0]}, for use by the future icache RAM.
- Sub-module `uart_rx_byte` contains the synchroniser, bit-timing counter and shift register. It exposes `byte_valid`, `byte_data` and `frame_err`. The parser lives in `icache_loader`.

## Test plan
All scenarios use `CLK_HZ=1000000`, `BAUD=100000` (10 clocks per bit) and `IMEM_WORDS=16`.
- Valid 2-word frame: send A5 00 02 12 34 AB CD, CHK=0x02^0x12^0x34^0xAB^0xCD=0x42. Expect writes (0,0x1234) then (1,0xABCD), `words_loaded=2`, `load_done=1`, `core_hold=0`, `load_error=0`.
- Same frame with CHK=0x43 → both words written, then `load_error=1`, `core_hold=1`, `load_done=0`.
- Length overflow: send A5 00 11 (N=17 > 16) → `load_error=1` after LEN_LO, no `icache_we`, and the next 0x11 byte is ignored in IDLE.
- N=0: send A5 00 00 00 → no writes, `load_done=1`, `core_hold=0`.
- Stop bit forced low on the DATA_HI byte → no write, `load_error=1`, FSM in IDLE. A following valid frame loads correctly.
- Assert `reset` for 1 cycle halfway through word 1 of a 4-word frame → all outputs return to reset values. A fresh valid frame then loads, starting at address 0.
